// File: rtl/slot_write_sched.sv
// Slot-synchronous write scheduler.
// A free-running {voice,env} slot counter sweeps the parameter store; host updates are
// queued and each is written back only when the counter reaches its target slot.
// Optional feature: define SLOT_WRITE_SCHED_STATS_EN to add a 16-bit commit counter output.
module slot_write_sched #(
  parameter int unsigned VOICES     = 8,
  parameter int unsigned V_ENVS     = 8,
  parameter int unsigned V_WIDTH    = 3,
  parameter int unsigned E_WIDTH    = 3,
  parameter int unsigned D_WIDTH    = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                       sCLK_XVXENVS,
  input  logic                       reset_reg,
  input  logic                       run,
  output logic [V_WIDTH+E_WIDTH-1:0] xxxx,
  output logic                       frame_start,
  input  logic                       upd_valid,
  output logic                       upd_ready,
  input  logic [V_WIDTH-1:0]         upd_voice,
  input  logic [E_WIDTH-1:0]         upd_env,
  input  logic [D_WIDTH-1:0]         upd_data,
  output logic                       wr_en,
  output logic [V_WIDTH+E_WIDTH-1:0] wr_addr,
  output logic [D_WIDTH-1:0]         wr_data,
`ifdef SLOT_WRITE_SCHED_STATS_EN
  output logic [15:0]                commit_cnt,
`endif
  output logic                       busy
);

  localparam int unsigned AW       = V_WIDTH + E_WIDTH;
  localparam int unsigned PW       = $clog2(FIFO_DEPTH);
  localparam int unsigned NumSlots = VOICES * V_ENVS;

  localparam logic [AW-1:0] LastSlot  = AW'(NumSlots - 1);
  localparam logic [AW:0]   NumSlotsW = (AW+1)'(NumSlots);
  localparam logic [PW:0]   FullCnt   = (PW+1)'(FIFO_DEPTH);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StWait   = 2'd1;
  localparam logic [1:0] StCommit = 2'd2;

  logic [AW-1:0]      slot_q, slot_d;
  logic [1:0]         state_q, state_d;
  logic [PW:0]        count_q, count_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      wr_addr_q, wr_addr_d;
  logic [D_WIDTH-1:0] wr_data_q, wr_data_d;

  logic [AW-1:0]      addr_mem [FIFO_DEPTH];
  logic [D_WIDTH-1:0] data_mem [FIFO_DEPTH];

  logic [AW-1:0] upd_target;
  logic          push;
  logic          push_keep;
  logic          pop;

  assign upd_target = {upd_voice, upd_env};
  assign upd_ready  = (count_q != FullCnt);
  assign push       = upd_valid && upd_ready;
  // Out-of-range targets complete the handshake but are never queued.
  assign push_keep  = push && ({1'b0, upd_target} < NumSlotsW);
  // Slot match is only evaluated while waiting, so COMMIT never matches.
  assign pop        = (state_q == StWait) && run && (count_q != '0) &&
                      (slot_q == addr_mem[rd_ptr_q]);

  assign xxxx        = slot_q;
  assign frame_start = run && (slot_q == '0);
  assign wr_en       = (state_q == StCommit);
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = (state_q != StIdle);

  // Slot counter, queue bookkeeping and write-back registers next state.
  always_comb begin
    slot_d    = slot_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (run) begin
      slot_d = (slot_q == LastSlot) ? '0 : slot_q + 1'b1;
    end
    if (push_keep) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      wr_addr_d = addr_mem[rd_ptr_q];
      wr_data_d = data_mem[rd_ptr_q];
    end
    unique case ({push_keep, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Scheduler FSM: wait for the head's slot, then hold the write strobe for one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (count_q != '0) state_d = StWait;
      StWait:   if (pop) state_d = StCommit;
      StCommit: state_d = (count_q != '0) ? StWait : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State registers; reset overrides every other update, aborting any pending commit.
  always_ff @(posedge sCLK_XVXENVS) begin
    if (reset_reg) begin
      slot_q    <= '0;
      state_q   <= StIdle;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      slot_q    <= slot_d;
      state_q   <= state_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Queue storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge sCLK_XVXENVS) begin
    if (!reset_reg && push_keep) begin
      addr_mem[wr_ptr_q] <= upd_target;
      data_mem[wr_ptr_q] <= upd_data;
    end
  end

`ifdef SLOT_WRITE_SCHED_STATS_EN
  logic [15:0] commit_cnt_q;

  // Count write strobes, wrapping naturally at 16 bits.
  always_ff @(posedge sCLK_XVXENVS) begin
    if (reset_reg) begin
      commit_cnt_q <= '0;
    end else if (state_q == StCommit) begin
      commit_cnt_q <= commit_cnt_q + 16'd1;
    end
  end

  assign commit_cnt = commit_cnt_q;
`endif

endmodule

// File: doc/slot_write_sched.md
SLOT_WRITE_SCHED -- requirements
Module: slot_write_sched

Interface
REQ-001 Parameter VOICES, default 8, number of voices.
REQ-002 Parameter V_ENVS, default 8, envelopes per voice.
REQ-003 Parameter V_WIDTH, default 3, voice field width; E_WIDTH, default 3, envelope field width.
REQ-004 Parameter D_WIDTH, default 8, update data width; FIFO_DEPTH, default 4, pending-update queue depth (power of 2).
REQ-005 sCLK_XVXENVS  in  1  single clock; all state on rising edge.
REQ-006 reset_reg  in  1  reset, synchronous, active-high.
REQ-007 run  in  1  slot counter advance enable.
REQ-008 xxxx  out  V_WIDTH+E_WIDTH  current slot index {voice,env}.
REQ-009 frame_start  out  1  high while xxxx==0 and run==1 (combinational).
REQ-010 upd_valid  in  1; upd_ready  out  1; upd_voice  in  V_WIDTH; upd_env  in  E_WIDTH; upd_data  in  D_WIDTH: host update request.
REQ-011 wr_en  out  1; wr_addr  out  V_WIDTH+E_WIDTH; wr_data  out  D_WIDTH: slot write strobe to parameter store.
REQ-012 busy  out  1  high whenever state != IDLE.

Function
REQ-013 Counter: if run==1, xxxx increments by 1 each edge; at VOICES*V_ENVS-1 it wraps to 0; if run==0, xxxx holds.
REQ-014 Accept: update enqueued on an edge with upd_valid&&upd_ready; target address = {upd_voice,upd_env}; FIFO order preserved.
REQ-015 upd_ready = !full; a same-cycle pop does not raise ready (no push when full).
REQ-016 States IDLE, WAIT, COMMIT.
REQ-017 IDLE -> WAIT on the edge where FIFO count > 0.
REQ-018 WAIT -> COMMIT on the edge where run==1 and xxxx == head target; head popped, wr_addr/wr_data loaded from head on that edge.
REQ-019 COMMIT lasts exactly 1 cycle, wr_en==1 only in COMMIT; then -> WAIT if count > 0, else IDLE.
REQ-020 Write latency: wr_en is high in the cycle after the cycle in which xxxx equals the target; no slot comparison is made during COMMIT.
REQ-021 Consecutive entries with the same target commit one full frame (VOICES*V_ENVS cycles) apart.
REQ-022 run==0: no commits; pushes still accepted until full.
REQ-023 Target >= VOICES*V_ENVS (non-power-of-2 configs) is accepted but dropped at enqueue; it never blocks the queue.

Reset
REQ-024 reset_reg==1 on an edge: xxxx=0, FIFO emptied, pending updates discarded, state IDLE, wr_en=0, wr_addr=0, wr_data=0; upd_ready=1 the cycle after.
REQ-025 Reset takes priority over push, pop, counting and commit in the same cycle; a commit in progress is aborted.

Configuration
REQ-026 Macro SLOT_WRITE_SCHED_STATS_EN defined: output commit_cnt (16 bits) counts wr_en pulses, wraps at 65535->0, and is cleared by reset.
REQ-027 SLOT_WRITE_SCHED_STATS_EN undefined: commit_cnt port and counter are absent; all other behaviour is identical.

Verification
REQ-028 Reset, then run=1 for 130 cycles -> xxxx steps 0..63,0..63,0,1; frame_start high at cycles 0, 64 and 128.
REQ-029 Push voice=2, env=5, data=0xA5 while xxxx=10 -> single wr_en pulse with wr_addr=21, wr_data=0xA5, one cycle after xxxx==21.
REQ-030 Push target 3 while xxxx=40 -> commit follows the wrap: wr_en one cycle after xxxx==3 of the next frame; busy high throughout the wait.
REQ-031 run=0; push 4 updates (targets 9, 4, 30, 12) -> upd_ready low after the 4th and a 5th valid is held; run=1 -> commits in order 9, 4, 30, 12, with 4 and 12 in the following frame(s).
REQ-032 Two pushes both targeting 7 -> two wr_en pulses exactly 64 cycles apart.
REQ-033 3 updates pending, reset_reg pulsed 1 cycle -> no wr_en afterwards, xxxx=0, busy=0, upd_ready=1; with the stats macro defined, commit_cnt=0.
